// File: rtl/bit_pattern_gen_pkg.sv
// ============================================================================
// Module      : bit_pattern_gen_pkg
// Description : Shared definitions for the serial bit-pattern generators.
//               Holds the FSM state encodings and the default widths so the
//               top level, its sub-module, sibling generators and benches all
//               agree on the same values.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Contents    : ST_IDLE / ST_RUN   - one-bit state encodings
//               DEF_PAT_W          - default maximum pattern length (bits)
//               DEF_LEN_W          - default width of the length field
//               DEF_HOLD_W         - default width of the per-bit hold count
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package bit_pattern_gen_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int DEF_PAT_W  = 8;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_HOLD_W = 8;

endpackage : bit_pattern_gen_pkg

`default_nettype wire

// File: rtl/bit_pattern_gen_hold_timer.sv
// ============================================================================
// Module      : hold_timer
// Description : Loadable down-counter that measures how long each pattern bit
//               stays on the output. Loading takes priority over counting;
//               the counter parks at zero and reports expiry while there.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk       in  1       - clock, rising edge
//               rst_n     in  1       - asynchronous active-low reset
//               load      in  1       - load load_val on the next edge
//               load_val  in  HOLD_W  - value to load (cycles remaining - 1)
//               expire    out 1       - counter is at zero
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hold_timer
  import bit_pattern_gen_pkg::*;
#(
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  output logic              expire
);

  logic [HOLD_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - HOLD_W'(1);
    end
  end

  // Derived straight from the counter register, so expiry is known at the
  // start of the cycle and the parent can act on it in the same cycle.
  assign expire = (r_cnt == '0);

endmodule : hold_timer

`default_nettype wire

// File: rtl/bit_pattern_gen.sv
// ============================================================================
// Module      : bit_pattern_gen
// Description : Programmable serial bit-pattern generator. A pattern is
//               captured at start and shifted out LSB first, each bit held
//               for a programmable number of cycles, with one-shot or
//               looping playback and a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk        in  1       - clock, rising edge
//               rst_n      in  1       - asynchronous active-low reset
//               start      in  1       - request playback (IDLE only)
//               stop       in  1       - synchronous abort while running
//               loop       in  1       - repeat pattern (sampled per pass end)
//               pattern    in  PAT_W   - bits to play, LSB first
//               len        in  LEN_W   - number of bits to play
//               hold       in  HOLD_W  - cycles per bit (0 behaves as 1)
//               bit_out    out 1       - registered serial output
//               bit_valid  out 1       - bit_out carries pattern data
//               bit_idx    out LEN_W   - index of the bit on bit_out
//               busy       out 1       - playback in progress
//               done       out 1       - one-cycle pulse on normal completion
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bit_pattern_gen
  import bit_pattern_gen_pkg::*;
#(
  parameter int   PAT_W      = DEF_PAT_W,
  parameter int   LEN_W      = DEF_LEN_W,
  parameter int   HOLD_W     = DEF_HOLD_W,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [PAT_W-1:0]  pattern,
  input  logic [LEN_W-1:0]  len,
  input  logic [HOLD_W-1:0] hold,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [LEN_W-1:0]  bit_idx,
  output logic              busy,
  output logic              done
);

  // --------------------------------------------------------------------------
  // State and shadow registers
  // --------------------------------------------------------------------------
  logic [0:0]        r_state;
  logic [PAT_W-1:0]  r_pat_q;
  logic [LEN_W-1:0]  r_len_q;
  logic [HOLD_W-1:0] r_hold_q;
  logic [LEN_W-1:0]  r_idx;
  logic              r_bit_out;
  logic              r_done;

  // --------------------------------------------------------------------------
  // Next-state wires
  // --------------------------------------------------------------------------
  logic [0:0]        w_state_nxt;
  logic              w_run;
  logic              w_accept;
  logic              w_expire;
  logic              w_tick;
  logic              w_last;
  logic              w_eop;
  logic              w_done_nxt;
  logic [LEN_W-1:0]  w_len_eff;
  logic [HOLD_W-1:0] w_hold_eff;
  logic [LEN_W-1:0]  w_idx_nxt;
  logic [PAT_W-1:0]  w_pat_nxt;
  logic              w_sel_bit;
  logic              w_load;
  logic [HOLD_W-1:0] w_load_val;

  // Length is clamped to the pattern width and a zero hold behaves as one
  // cycle, so the shadow registers always hold directly usable values.
  assign w_len_eff  = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
  assign w_hold_eff = (hold == '0) ? HOLD_W'(1) : hold;

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = (r_state == ST_IDLE) && start && (len != '0);
  assign w_tick   = w_run && w_expire;
  assign w_last   = (r_idx == (r_len_q - LEN_W'(1)));
  assign w_eop    = w_tick && w_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN: begin
        // Abort wins over a simultaneous end of pass.
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_eop && !loop) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_done_nxt = w_eop && !loop && !stop;

  always_comb begin
    w_idx_nxt = r_idx;
    if ((w_state_nxt == ST_IDLE) || w_accept) begin
      w_idx_nxt = '0;
    end else if (w_tick) begin
      w_idx_nxt = w_last ? '0 : (r_idx + LEN_W'(1));
    end
  end

  // The output register is loaded from the *next* index and pattern, which
  // is what lets pattern[0] appear right after the accepting edge.
  assign w_pat_nxt = w_accept ? pattern : r_pat_q;

  always_comb begin
    w_sel_bit = IDLE_LEVEL;
    for (int i = 0; i < PAT_W; i++) begin
      if (w_idx_nxt == LEN_W'(i)) begin
        w_sel_bit = w_pat_nxt[i];
      end
    end
  end

  // The timer is reloaded on acceptance and at every bit boundary; between
  // boundaries it counts down on its own.
  assign w_load     = w_accept || w_tick;
  assign w_load_val = w_accept ? (w_hold_eff - HOLD_W'(1))
                               : (r_hold_q - HOLD_W'(1));

  hold_timer #(
    .HOLD_W (HOLD_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .expire   (w_expire)
  );

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pat_q   <= '0;
      r_len_q   <= '0;
      r_hold_q  <= '0;
      r_idx     <= '0;
      r_bit_out <= IDLE_LEVEL;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_pat_q  <= pattern;
        r_len_q  <= w_len_eff;
        r_hold_q <= w_hold_eff;
      end
      r_bit_out <= (w_state_nxt == ST_RUN) ? w_sel_bit : IDLE_LEVEL;
    end
  end

  assign bit_out   = r_bit_out;
  assign bit_valid = (r_state == ST_RUN);
  assign busy      = (r_state == ST_RUN);
  assign bit_idx   = r_idx;
  assign done      = r_done;

endmodule : bit_pattern_gen

`default_nettype wire
